// File: rtl/i2c_xfer_ctrl_pkg.sv
// rtl/i2c_xfer_ctrl_pkg.sv - shared constants, enums and helpers for the I2C transfer sequencer
// Contents: core register addresses, CR command bits, SR bit indices,
//           transfer error codes, sequencer state encoding, CR-per-step helper.
package i2c_xfer_ctrl_pkg;

    // Wishbone register map of the I2C master core
    localparam logic [2:0] ADR_PRER_LO = 3'b000;
    localparam logic [2:0] ADR_PRER_HI = 3'b001;
    localparam logic [2:0] ADR_CTR     = 3'b010;
    localparam logic [2:0] ADR_TXR     = 3'b011;
    localparam logic [2:0] ADR_RXR     = 3'b011;
    localparam logic [2:0] ADR_CR      = 3'b100;
    localparam logic [2:0] ADR_SR      = 3'b100;

    // Command register bits
    localparam logic [7:0] CR_STA  = 8'h80;
    localparam logic [7:0] CR_STO  = 8'h40;
    localparam logic [7:0] CR_RD   = 8'h20;
    localparam logic [7:0] CR_WR   = 8'h10;
    localparam logic [7:0] CR_ACK  = 8'h08;
    localparam logic [7:0] CR_IACK = 8'h01;

    // Control register: core enable
    localparam logic [7:0] CTR_EN = 8'h80;

    // Status register bit positions
    localparam int unsigned SR_IF    = 0;
    localparam int unsigned SR_AL    = 5;
    localparam int unsigned SR_RXACK = 7;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_NACK    = 2'd1,
        ERR_AL      = 2'd2,
        ERR_TIMEOUT = 2'd3
    } xfer_err_t;

    typedef enum logic [3:0] {
        ST_INIT_PRL,
        ST_INIT_PRH,
        ST_INIT_CTR,
        ST_IDLE,
        ST_LOAD_TXR,
        ST_LOAD_CR,
        ST_GAP,
        ST_POLL,
        ST_CHECK,
        ST_READ_RXR,
        ST_ABORT,
        ST_CLEAR,
        ST_RESP
    } xfer_state_t;

    // Command issued for byte step 0..3; step 2 is the repeated start on reads
    // and the final data byte (with stop) on writes.
    function automatic logic [7:0] cr_for_step(input logic [1:0] step, input logic rd);
        logic [7:0] cr;
        case (step)
            2'd0:    cr = CR_STA | CR_WR | CR_IACK;
            2'd1:    cr = CR_WR | CR_IACK;
            2'd2:    cr = rd ? (CR_STA | CR_WR | CR_IACK) : (CR_STO | CR_WR | CR_IACK);
            default: cr = CR_RD | CR_ACK | CR_STO | CR_IACK;
        endcase
        return cr;
    endfunction

endpackage

// File: rtl/i2c_xfer_ctrl_if.sv
// rtl/i2c_xfer_ctrl_if.sv - host request/response port plus Wishbone master bus of the sequencer
// slave modport: sequencer view (accepts requests, masters the Wishbone bus).
// master modport: host/environment view (issues requests, acts as Wishbone slave).
interface i2c_xfer_ctrl_if;
    logic       req_valid_i;
    logic       req_ready_o;
    logic       req_rd_i;
    logic [6:0] req_dev_i;
    logic [7:0] req_reg_i;
    logic [7:0] req_wdata_i;
    logic       rsp_valid_o;
    logic [7:0] rsp_rdata_o;
    logic [1:0] rsp_err_o;
    logic [2:0] wbm_adr_o;
    logic [7:0] wbm_dat_o;
    logic [7:0] wbm_dat_i;
    logic       wbm_we_o;
    logic       wbm_stb_o;
    logic       wbm_cyc_o;
    logic       wbm_ack_i;

    modport slave (
        input  req_valid_i, req_rd_i, req_dev_i, req_reg_i, req_wdata_i,
        input  wbm_dat_i, wbm_ack_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_stb_o, wbm_cyc_o
    );

    modport master (
        output req_valid_i, req_rd_i, req_dev_i, req_reg_i, req_wdata_i,
        output wbm_dat_i, wbm_ack_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_stb_o, wbm_cyc_o
    );
endinterface

// File: rtl/i2c_xfer_ctrl_wbm_port.sv
// rtl/i2c_xfer_ctrl_wbm_port.sv - single Wishbone read/write engine
// Ports: wb_clk_i/arst_i clock and async active-low reset; start/adr/we/wdata
//        launch one cycle; busy while the cycle is open; done pulses with the ack;
//        rdata holds the last read value; wbm_* drive/receive the Wishbone bus.
module i2c_wbm_port (
    input  logic       wb_clk_i,
    input  logic       arst_i,
    input  logic       start,
    input  logic [2:0] adr,
    input  logic       we,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic [2:0] wbm_adr,
    output logic [7:0] wbm_dat,
    output logic       wbm_we,
    output logic       wbm_stb,
    output logic       wbm_cyc,
    input  logic [7:0] wbm_rdat,
    input  logic       wbm_ack
);

    logic       active;
    logic [2:0] adr_q;
    logic [7:0] dat_q;
    logic       we_q;

    // start is only honoured while idle, so after an ack stb/cyc are low for
    // at least the following cycle. An ack seen while idle is ignored.
    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            active <= 1'b0;
            adr_q  <= 3'd0;
            dat_q  <= 8'd0;
            we_q   <= 1'b0;
            rdata  <= 8'd0;
        end else if (!active) begin
            if (start) begin
                active <= 1'b1;
                adr_q  <= adr;
                dat_q  <= wdata;
                we_q   <= we;
            end
        end else if (wbm_ack) begin
            active <= 1'b0;
            if (!we_q) begin
                rdata <= wbm_rdat;
            end
        end
    end

    assign busy    = active;
    assign done    = active & wbm_ack;
    assign wbm_adr = adr_q;
    assign wbm_dat = dat_q;
    assign wbm_we  = we_q & active;
    assign wbm_stb = active;
    assign wbm_cyc = active;

endmodule

// File: rtl/i2c_xfer_ctrl.sv
// rtl/i2c_xfer_ctrl.sv - sequencer turning register read/write requests into I2C core bus cycles
// Ports: wb_clk_i clock; arst_i async active-low reset; bus (slave modport) carries
//        the host request/response handshake and the Wishbone master signals.
// Parameters: PRESCALE written to PRER at init; POLL_TIMEOUT max SR polls per byte.
module i2c_xfer_ctrl
    import i2c_xfer_ctrl_pkg::*;
#(
    parameter logic [15:0] PRESCALE     = 16'h00C7,
    parameter logic [15:0] POLL_TIMEOUT = 16'hFFFF
) (
    input  logic          wb_clk_i,
    input  logic          arst_i,
    i2c_xfer_ctrl_if.slave bus
);

    xfer_state_t state, nxt;

    logic       bus_start, bus_we, bus_busy, bus_done;
    logic [2:0] bus_adr;
    logic [7:0] bus_wdata, bus_rdata;

    logic       rd_q;
    logic [6:0] dev_q;
    logic [7:0] reg_q, wdata_q;
    logic [1:0] step;
    logic [15:0] poll_cnt;
    logic       gap_cnt;
    logic       aborting;
    xfer_err_t  err_q;
    logic [7:0] rsp_rdata_q;
    xfer_err_t  rsp_err_q;

    logic [7:0] txr_byte;
    logic       sr_if, sr_al, sr_nack, poll_expired, last_step;

    i2c_wbm_port u_port (
        .wb_clk_i (wb_clk_i),
        .arst_i   (arst_i),
        .start    (bus_start),
        .adr      (bus_adr),
        .we       (bus_we),
        .wdata    (bus_wdata),
        .busy     (bus_busy),
        .done     (bus_done),
        .rdata    (bus_rdata),
        .wbm_adr  (bus.wbm_adr_o),
        .wbm_dat  (bus.wbm_dat_o),
        .wbm_we   (bus.wbm_we_o),
        .wbm_stb  (bus.wbm_stb_o),
        .wbm_cyc  (bus.wbm_cyc_o),
        .wbm_rdat (bus.wbm_dat_i),
        .wbm_ack  (bus.wbm_ack_i)
    );

    always_comb begin
        case (step)
            2'd0:    txr_byte = {dev_q, 1'b0};
            2'd1:    txr_byte = reg_q;
            2'd2:    txr_byte = rd_q ? {dev_q, 1'b1} : wdata_q;
            default: txr_byte = 8'd0;
        endcase
    end

    // SR decode, valid in CHECK (rdata holds the SR value from the poll just done).
    // RxACK is meaningless on the read byte, which we NACK ourselves.
    assign sr_if        = bus_rdata[SR_IF];
    assign sr_al        = bus_rdata[SR_AL];
    assign sr_nack      = bus_rdata[SR_RXACK] && !(rd_q && step == 2'd3);
    assign poll_expired = ({1'b0, poll_cnt} + 17'd1) >= {1'b0, POLL_TIMEOUT};
    assign last_step    = rd_q ? (step == 2'd3) : (step == 2'd2);

    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state <= ST_INIT_PRL;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_INIT_PRL: if (bus_done) nxt = ST_INIT_PRH;
            ST_INIT_PRH: if (bus_done) nxt = ST_INIT_CTR;
            ST_INIT_CTR: if (bus_done) nxt = ST_IDLE;
            ST_IDLE:     if (bus.req_valid_i) nxt = ST_LOAD_TXR;
            ST_LOAD_TXR: if (bus_done) nxt = ST_LOAD_CR;
            ST_LOAD_CR:  if (bus_done) nxt = ST_GAP;
            ST_GAP:      if (gap_cnt) nxt = ST_POLL;
            ST_POLL:     if (bus_done) nxt = ST_CHECK;
            ST_CHECK: begin
                if (!sr_if) begin
                    // A timeout while already stopping after a NACK goes straight to cleanup
                    if (poll_expired) nxt = aborting ? ST_CLEAR : ST_ABORT;
                    else              nxt = ST_POLL;
                end else if (aborting || sr_al) begin
                    nxt = ST_CLEAR;
                end else if (sr_nack) begin
                    nxt = ST_ABORT;
                end else if (last_step) begin
                    nxt = rd_q ? ST_READ_RXR : ST_CLEAR;
                end else begin
                    // The read byte (step 3) has no TXR load
                    nxt = (rd_q && step == 2'd2) ? ST_LOAD_CR : ST_LOAD_TXR;
                end
            end
            ST_READ_RXR: if (bus_done) nxt = ST_CLEAR;
            // Only a NACK stop is polled for completion; a timeout stop is not
            ST_ABORT:    if (bus_done) nxt = (err_q == ERR_NACK) ? ST_GAP : ST_CLEAR;
            ST_CLEAR:    if (bus_done) nxt = ST_RESP;
            ST_RESP:     nxt = ST_IDLE;
            default:     nxt = ST_INIT_PRL;
        endcase
    end

    always_comb begin
        bus_start = 1'b0;
        bus_adr   = 3'd0;
        bus_we    = 1'b0;
        bus_wdata = 8'd0;
        case (state)
            ST_INIT_PRL: begin
                bus_start = !bus_busy; bus_adr = ADR_PRER_LO; bus_we = 1'b1; bus_wdata = PRESCALE[7:0];
            end
            ST_INIT_PRH: begin
                bus_start = !bus_busy; bus_adr = ADR_PRER_HI; bus_we = 1'b1; bus_wdata = PRESCALE[15:8];
            end
            ST_INIT_CTR: begin
                bus_start = !bus_busy; bus_adr = ADR_CTR; bus_we = 1'b1; bus_wdata = CTR_EN;
            end
            ST_LOAD_TXR: begin
                bus_start = !bus_busy; bus_adr = ADR_TXR; bus_we = 1'b1; bus_wdata = txr_byte;
            end
            ST_LOAD_CR: begin
                bus_start = !bus_busy; bus_adr = ADR_CR; bus_we = 1'b1; bus_wdata = cr_for_step(step, rd_q);
            end
            ST_POLL: begin
                bus_start = !bus_busy; bus_adr = ADR_SR;
            end
            ST_READ_RXR: begin
                bus_start = !bus_busy; bus_adr = ADR_RXR;
            end
            ST_ABORT: begin
                bus_start = !bus_busy; bus_adr = ADR_CR; bus_we = 1'b1; bus_wdata = CR_STO | CR_IACK;
            end
            ST_CLEAR: begin
                bus_start = !bus_busy; bus_adr = ADR_CR; bus_we = 1'b1; bus_wdata = CR_IACK;
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            rd_q        <= 1'b0;
            dev_q       <= 7'd0;
            reg_q       <= 8'd0;
            wdata_q     <= 8'd0;
            step        <= 2'd0;
            poll_cnt    <= 16'd0;
            gap_cnt     <= 1'b0;
            aborting    <= 1'b0;
            err_q       <= ERR_OK;
            rsp_rdata_q <= 8'd0;
            rsp_err_q   <= ERR_OK;
        end else begin
            gap_cnt <= (state == ST_GAP);
            if (state == ST_IDLE && bus.req_valid_i) begin
                rd_q     <= bus.req_rd_i;
                dev_q    <= bus.req_dev_i;
                reg_q    <= bus.req_reg_i;
                wdata_q  <= bus.req_wdata_i;
                step     <= 2'd0;
                err_q    <= ERR_OK;
                aborting <= 1'b0;
            end
            // Every byte step (and the NACK stop) passes GAP before polling
            if (state == ST_GAP) begin
                poll_cnt <= 16'd0;
            end else if (state == ST_CHECK && !sr_if && poll_cnt != 16'hFFFF) begin
                poll_cnt <= poll_cnt + 16'd1;
            end
            if (state == ST_CHECK) begin
                if (!sr_if) begin
                    if (poll_expired) err_q <= ERR_TIMEOUT;
                end else if (!aborting) begin
                    if (sr_al) begin
                        err_q <= ERR_AL;
                    end else if (sr_nack) begin
                        err_q    <= ERR_NACK;
                        aborting <= 1'b1;
                    end else if (!last_step) begin
                        step <= step + 2'd1;
                    end
                end
            end
            // bus_rdata still holds RXR here: CLEAR is a write
            if (state == ST_CLEAR && bus_done) begin
                rsp_rdata_q <= (rd_q && err_q == ERR_OK) ? bus_rdata : 8'd0;
                rsp_err_q   <= err_q;
            end
        end
    end

    assign bus.req_ready_o = (state == ST_IDLE);
    assign bus.rsp_valid_o = (state == ST_RESP);
    assign bus.rsp_rdata_o = rsp_rdata_q;
    assign bus.rsp_err_o   = rsp_err_q;

endmodule
